filt2_tx: RTL and testbench



---
 rtl/filt2_tx.sv | 98 +++++++++
 tb/tb_filt2_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filt2_tx.sv
// filt2_tx: drives y so that every level change is held for at least HOLD clk cycles.
// Optional macro FILT2_TX_PULSE_LATCH_EN latches requests that revert inside a dwell.
module filt2_tx #(
    parameter int HOLD = 3,
    parameter int CW   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic y,
    output logic busy
);

    typedef enum logic [1:0] {
        LO      = 2'd0,
        LO_HOLD = 2'd1,
        HI      = 2'd2,
        HI_HOLD = 2'd3
    } state_t;

    localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

    state_t        state_q, state_d;
    logic          y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_hold;
    logic          pending;

`ifdef FILT2_TX_PULSE_LATCH_EN
    logic pending_q, pending_d;
    assign pending = pending_q;
`else
    assign pending = 1'b0;
`endif

    assign in_hold = (state_q == LO_HOLD) || (state_q == HI_HOLD);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            LO, HI: begin
                if (req != y_q) begin
                    y_d     = req;
                    state_d = req ? HI_HOLD : LO_HOLD;
                    cnt_d   = LOAD;
                end
            end
            LO_HOLD, HI_HOLD: begin
                // The decrement is gated by cnt!=0, so the counter never wraps.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if ((req != y_q) || pending) begin
                    y_d     = ~y_q;
                    state_d = y_q ? LO_HOLD : HI_HOLD;
                    cnt_d   = LOAD;
                end else begin
                    state_d = y_q ? HI : LO;
                end
            end
        endcase
    end

`ifdef FILT2_TX_PULSE_LATCH_EN
    // A mismatch seen while the dwell runs is remembered; the expiry edge consumes it.
    always_comb begin
        pending_d = pending_q;
        if (in_hold) begin
            pending_d = (cnt_q != '0) && ((req != y_q) || pending_q);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LO;
            y_q       <= 1'b0;
            cnt_q     <= '0;
`ifdef FILT2_TX_PULSE_LATCH_EN
            pending_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= state_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
`ifdef FILT2_TX_PULSE_LATCH_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign y    = y_q;
    assign busy = in_hold;

endmodule

// File: tb/tb_filt2_tx.sv
// Self-checking bench for filt2_tx: vector tables, hand sequences and a random run
// compared against a dwell-age model of the line.
module tb_filt2_tx;

    localparam int HOLD = 3;

    logic clk;
    logic rst_n;
    logic req;
    logic y;
    logic busy;

    filt2_tx #(.HOLD(HOLD), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .y     (y),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: y may only change once it has been stable for HOLD edges.
    int   m_since;
    logic m_y;
    logic m_pend;

    task automatic model_reset();
        m_since = HOLD;
        m_y     = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge(input logic r);
        if (m_since < HOLD) m_since++;
        if (m_since >= HOLD) begin
            if ((r != m_y) || m_pend) begin
                m_y     = ~m_y;
                m_since = 0;
                m_pend  = 1'b0;
            end
        end else if (r != m_y) begin
`ifdef FILT2_TX_PULSE_LATCH_EN
            m_pend = 1'b1;
`endif
        end
    endtask

    task automatic step(input logic r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
        model_edge(r);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_y", y, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Dwell monitor: every change of y must follow at least HOLD stable cycles.
    int   run_len;
    logic y_prev;
    initial begin
        run_len = HOLD;
        y_prev  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                run_len = HOLD;
                y_prev  = y;
            end else begin
                if (y !== y_prev) begin
                    tests++;
                    if (run_len < HOLD) begin
                        fails++;
                        $display("FAIL dwell: got %0d cycles required >= %0d (t=%0t)", run_len, HOLD, $time);
                    end
                    run_len = 1;
                end else if (run_len < HOLD) begin
                    run_len++;
                end
                y_prev = y;
            end
        end
    end

    typedef struct {
        logic r;
        logic ey;
        logic eb;
    } vec_t;

    vec_t pulse_tbl[15];
    vec_t glitch_tbl[10];

    initial begin
        // Pulse from LO, then a second request raised inside the low dwell.
        pulse_tbl[0]  = '{1'b1, 1'b1, 1'b1};
        pulse_tbl[1]  = '{1'b0, 1'b1, 1'b1};
        pulse_tbl[2]  = '{1'b0, 1'b1, 1'b1};
        pulse_tbl[3]  = '{1'b0, 1'b0, 1'b1};
        pulse_tbl[4]  = '{1'b1, 1'b0, 1'b1};
        pulse_tbl[5]  = '{1'b1, 1'b0, 1'b1};
        pulse_tbl[6]  = '{1'b1, 1'b1, 1'b1};
        pulse_tbl[7]  = '{1'b1, 1'b1, 1'b1};
        pulse_tbl[8]  = '{1'b1, 1'b1, 1'b1};
        pulse_tbl[9]  = '{1'b1, 1'b1, 1'b0};
        pulse_tbl[10] = '{1'b1, 1'b1, 1'b0};
        pulse_tbl[11] = '{1'b0, 1'b0, 1'b1};
        pulse_tbl[12] = '{1'b0, 1'b0, 1'b1};
        pulse_tbl[13] = '{1'b0, 1'b0, 1'b1};
        pulse_tbl[14] = '{1'b0, 1'b0, 1'b0};

        // One-cycle low glitch at dwell cycle 1 of a high level.
        glitch_tbl[0] = '{1'b1, 1'b1, 1'b1};
        glitch_tbl[1] = '{1'b0, 1'b1, 1'b1};
        glitch_tbl[2] = '{1'b1, 1'b1, 1'b1};
`ifdef FILT2_TX_PULSE_LATCH_EN
        glitch_tbl[3] = '{1'b1, 1'b0, 1'b1};
        glitch_tbl[4] = '{1'b1, 1'b0, 1'b1};
        glitch_tbl[5] = '{1'b1, 1'b0, 1'b1};
        glitch_tbl[6] = '{1'b1, 1'b1, 1'b1};
        glitch_tbl[7] = '{1'b1, 1'b1, 1'b1};
        glitch_tbl[8] = '{1'b1, 1'b1, 1'b1};
        glitch_tbl[9] = '{1'b1, 1'b1, 1'b0};
`else
        glitch_tbl[3] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[4] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[5] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[6] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[7] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[8] = '{1'b1, 1'b1, 1'b0};
        glitch_tbl[9] = '{1'b1, 1'b1, 1'b0};
`endif

        rst_n = 1'b0;
        req   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_y", y, 1'b0);
        check("init_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("idle_y", y, 1'b0);
            check("idle_busy", busy, 1'b0);
        end

        for (int i = 0; i < 15; i++) begin
            step(pulse_tbl[i].r);
            check("pulse_y", y, pulse_tbl[i].ey);
            check("pulse_busy", busy, pulse_tbl[i].eb);
        end

        // Level step: a held request gives a 3-cycle busy window, then y stays high.
        for (int i = 0; i < 4; i++) step(1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check("step_y", y, 1'b1);
            check("step_busy", busy, (i < HOLD) ? 1'b1 : 1'b0);
        end

        // Request toggling every cycle yields a 3-high/3-low square wave.
        reset_dut();
        for (int i = 0; i < 30; i++) begin
            step((i % 2) == 0);
            check("toggle_y", y, ((i / HOLD) % 2) == 0);
            check("toggle_busy", busy, 1'b1);
        end

        reset_dut();
        for (int i = 0; i < 10; i++) begin
            step(glitch_tbl[i].r);
            check("glitch_y", y, glitch_tbl[i].ey);
            check("glitch_busy", busy, glitch_tbl[i].eb);
        end

        // Asynchronous reset in the middle of a high dwell.
        reset_dut();
        step(1'b1);
        check("ahold_y", y, 1'b1);
        check("ahold_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("arst_y", y, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("arst_hold_y", y, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("arel_y", y, 1'b1);
            check("arel_busy", busy, (i < HOLD) ? 1'b1 : 1'b0);
        end

        // Random request traffic at several change densities against the model.
        reset_dut();
        for (int blk = 0; blk < 8; blk++) begin
            int p;
            case (blk % 4)
                0:       p = 10;
                1:       p = 35;
                2:       p = 60;
                default: p = 90;
            endcase
            for (int i = 0; i < 60; i++) begin
                logic r;
                r = ($urandom_range(0, 99) < p) ? ~req : req;
                step(r);
                check("rand_y", y, m_y);
                check("rand_busy", busy, (m_since < HOLD));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
